// File: rtl/image_op_sched.sv
// rtl/image_op_sched.sv - row-major coordinate scheduler for gray/sepia/crop/blur filter scans
// Accepts one command in IDLE, walks its window with a valid/ready handshake, then pulses done.
module image_op_sched #(
   parameter int WIDTH  = 768,
   parameter int HEIGHT = 512
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_sel,
   input  logic [15:0] cmd_left,
   input  logic [15:0] cmd_right,
   input  logic [15:0] cmd_top,
   input  logic [15:0] cmd_bottom,
   input  logic        abort,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic [15:0] pix_x,
   output logic [15:0] pix_y,
   output logic [1:0]  pix_sel,
   output logic        pix_last,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam logic [1:0]  ST_IDLE = 2'd0;
   localparam logic [1:0]  ST_SCAN = 2'd1;
   localparam logic [1:0]  ST_DONE = 2'd2;

   localparam logic [15:0] X_MAX = 16'(WIDTH - 1);
   localparam logic [15:0] Y_MAX = 16'(HEIGHT - 1);
   localparam logic [15:0] X_INT = 16'(WIDTH - 2);
   localparam logic [15:0] Y_INT = 16'(HEIGHT - 2);

   logic [1:0]  r_state;
   logic [15:0] r_xmin, r_xmax, r_ymax;
   logic [15:0] r_pix_x, r_pix_y;
   logic [1:0]  r_pix_sel;
   logic        r_pix_valid, r_pix_last, r_busy, r_done, r_err;

   logic [15:0] w_xmin, w_xmax, w_ymin, w_ymax;
   logic [15:0] w_nx, w_ny;
   logic        w_bad, w_row_end;

   always_comb begin
      w_xmin = 16'd0;
      w_xmax = X_MAX;
      w_ymin = 16'd0;
      w_ymax = Y_MAX;
      case (cmd_sel)
         2'd2: begin
            w_xmin = cmd_left;
            w_xmax = cmd_right;
            w_ymin = cmd_top;
            w_ymax = cmd_bottom;
         end
         2'd3: begin
            w_xmin = 16'd1;
            w_xmax = X_INT;
            w_ymin = 16'd1;
            w_ymax = Y_INT;
         end
         default: ;
      endcase
   end

   // right>=WIDTH is expressed as right>WIDTH-1 so the bound fits in 16 bits
   assign w_bad = (cmd_sel == 2'd2) &&
                  ((cmd_left > cmd_right) || (cmd_top > cmd_bottom) ||
                   (cmd_right > X_MAX) || (cmd_bottom > Y_MAX));

   assign w_row_end = (r_pix_x == r_xmax);
   assign w_nx      = w_row_end ? r_xmin : r_pix_x + 16'd1;
   assign w_ny      = w_row_end ? r_pix_y + 16'd1 : r_pix_y;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_xmin      <= 16'd0;
         r_xmax      <= 16'd0;
         r_ymax      <= 16'd0;
         r_pix_x     <= 16'd0;
         r_pix_y     <= 16'd0;
         r_pix_sel   <= 2'd0;
         r_pix_valid <= 1'b0;
         r_pix_last  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  if (w_bad) begin
                     r_err <= 1'b1;
                  end else begin
                     r_state     <= ST_SCAN;
                     r_xmin      <= w_xmin;
                     r_xmax      <= w_xmax;
                     r_ymax      <= w_ymax;
                     r_pix_x     <= w_xmin;
                     r_pix_y     <= w_ymin;
                     r_pix_sel   <= cmd_sel;
                     r_pix_last  <= (w_xmin == w_xmax) && (w_ymin == w_ymax);
                     r_pix_valid <= 1'b1;
                     r_busy      <= 1'b1;
                  end
               end
            end
            ST_SCAN: begin
               // abort wins over a handshake landing on the same edge
               if (abort) begin
                  r_state     <= ST_IDLE;
                  r_pix_valid <= 1'b0;
                  r_pix_last  <= 1'b0;
                  r_busy      <= 1'b0;
               end else if (pix_ready) begin
                  if (r_pix_last) begin
                     r_state     <= ST_DONE;
                     r_pix_valid <= 1'b0;
                     r_pix_last  <= 1'b0;
                     r_busy      <= 1'b0;
                     r_done      <= 1'b1;
                  end else begin
                     r_pix_x    <= w_nx;
                     r_pix_y    <= w_ny;
                     r_pix_last <= (w_nx == r_xmax) && (w_ny == r_ymax);
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready = rst_n && (r_state == ST_IDLE);
   assign pix_valid = r_pix_valid;
   assign pix_x     = r_pix_x;
   assign pix_y     = r_pix_y;
   assign pix_sel   = r_pix_sel;
   assign pix_last  = r_pix_last;
   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;

endmodule

// File: tb/tb_image_op_sched.sv
// tb/tb_image_op_sched.sv - randomized self-checking bench for image_op_sched on a 4x3 frame
// Expected coordinate lists are built from the window rules, not from the RTL's state.
module tb_image_op_sched;
   localparam int W = 4;
   localparam int H = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0, abort = 1'b0, pix_ready = 1'b0;
   logic [1:0]  cmd_sel = 2'd0;
   logic [15:0] cmd_left = 0, cmd_right = 0, cmd_top = 0, cmd_bottom = 0;
   logic        cmd_ready, pix_valid, pix_last, busy, done, err;
   logic [15:0] pix_x, pix_y;
   logic [1:0]  pix_sel;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   image_op_sched #(.WIDTH(W), .HEIGHT(H)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_sel(cmd_sel), .cmd_left(cmd_left), .cmd_right(cmd_right),
      .cmd_top(cmd_top), .cmd_bottom(cmd_bottom), .abort(abort),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
      .pix_sel(pix_sel), .pix_last(pix_last), .busy(busy), .done(done), .err(err)
   );

   // ready_mode: 0 random, 1 always, 2 toggle 1/0; abort_at: coordinate index to abort on, -1 none
   task automatic do_scan(input logic [1:0] sel, input int l, input int r, input int t,
                          input int b, input int ready_mode, input int abort_at);
      int qx[$], qy[$];
      int xmin, xmax, ymin, ymax, idx, cyc;
      bit ok, held;
      logic [15:0] hx, hy;
      logic hl;
      xmin = 0; xmax = W - 1; ymin = 0; ymax = H - 1;
      if (sel == 2'd3) begin xmin = 1; xmax = W - 2; ymin = 1; ymax = H - 2; end
      if (sel == 2'd2) begin xmin = l; xmax = r; ymin = t; ymax = b; end
      ok = !(sel == 2'd2 && (l > r || t > b || r >= W || b >= H));
      for (int y = ymin; y <= ymax; y++)
         for (int x = xmin; x <= xmax; x++) begin qx.push_back(x); qy.push_back(y); end

      @(negedge clk);
      cmd_valid = 1'b1; cmd_sel = sel;
      cmd_left = 16'(l); cmd_right = 16'(r); cmd_top = 16'(t); cmd_bottom = 16'(b);
      pix_ready = 1'b0;
      n_checks++;
      if (cmd_ready !== 1'b1) $display("FAIL cmd_ready_before_accept got %b want 1", cmd_ready);
      else n_pass++;
      @(negedge clk);
      cmd_valid = 1'b0;
      if (!ok) begin
         n_checks++;
         if ({err, pix_valid, busy, cmd_ready} !== 4'b1001)
            $display("FAIL bad_crop_err got err/valid/busy/ready=%b%b%b%b want 1001",
                     err, pix_valid, busy, cmd_ready);
         else n_pass++;
         @(negedge clk);
         n_checks++;
         if ({err, pix_valid, cmd_ready} !== 3'b001)
            $display("FAIL bad_crop_after got err/valid/ready=%b%b%b want 001", err, pix_valid, cmd_ready);
         else n_pass++;
         return;
      end
      n_checks++;
      if ({busy, cmd_ready, err} !== 3'b100)
         $display("FAIL scan_start got busy/ready/err=%b%b%b want 100", busy, cmd_ready, err);
      else n_pass++;

      idx = 0; held = 0; hx = 0; hy = 0; hl = 0;
      for (cyc = 0; cyc < 500; cyc++) begin
         case (ready_mode)
            1:       pix_ready = 1'b1;
            2:       pix_ready = (cyc % 2 == 0);
            default: pix_ready = 1'($urandom_range(1));
         endcase
         cmd_sel = 2'($urandom); cmd_left = 16'($urandom_range(5)); cmd_right = 16'($urandom_range(5));
         cmd_top = 16'($urandom_range(5)); cmd_bottom = 16'($urandom_range(5));
         if (held) begin
            n_checks++;
            if ({pix_x, pix_y, pix_last} !== {hx, hy, hl})
               $display("FAIL stall_hold got (%0d,%0d,last=%b) want (%0d,%0d,last=%b)",
                        pix_x, pix_y, pix_last, hx, hy, hl);
            else n_pass++;
         end
         n_checks++;
         if ({pix_valid, pix_x, pix_y, pix_last, pix_sel} !==
             {1'b1, 16'(qx[idx]), 16'(qy[idx]), idx == qx.size() - 1, sel})
            $display("FAIL coord_%0d got v=%b (%0d,%0d) last=%b sel=%0d want v=1 (%0d,%0d) last=%b sel=%0d",
                     idx, pix_valid, pix_x, pix_y, pix_last, pix_sel, qx[idx], qy[idx],
                     idx == qx.size() - 1, sel);
         else n_pass++;
         if (idx == abort_at) begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            n_checks++;
            if ({pix_valid, busy, done, cmd_ready} !== 4'b0001)
               $display("FAIL abort_idle got valid/busy/done/ready=%b%b%b%b want 0001",
                        pix_valid, busy, done, cmd_ready);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if ({done, pix_valid} !== 2'b00) $display("FAIL abort_no_done got done/valid=%b%b want 00", done, pix_valid);
            else n_pass++;
            return;
         end
         held = !pix_ready; hx = pix_x; hy = pix_y; hl = pix_last;
         if (pix_ready) idx++;
         @(negedge clk);
         if (idx == qx.size()) begin
            pix_ready = 1'b0;
            n_checks++;
            if ({done, busy, pix_valid, cmd_ready} !== 4'b1000)
               $display("FAIL done_pulse got done/busy/valid/ready=%b%b%b%b want 1000",
                        done, busy, pix_valid, cmd_ready);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if ({done, cmd_ready} !== 2'b01) $display("FAIL after_done got done/ready=%b%b want 01", done, cmd_ready);
            else n_pass++;
            return;
         end
      end
      n_checks++;
      $display("FAIL scan_timeout got %0d of %0d coordinates", idx, qx.size());
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_checks++;
      if ({pix_valid, pix_x, pix_y, pix_sel, pix_last, busy, done, err} !== 39'd0)
         $display("FAIL reset_outputs got v=%b x=%0d y=%0d sel=%0d last=%b busy=%b done=%b err=%b want all 0",
                  pix_valid, pix_x, pix_y, pix_sel, pix_last, busy, done, err);
      else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b want 1", cmd_ready);
      else n_pass++;
   endtask

   task automatic test_full_frame(); do_scan(2'd0, 0, 0, 0, 0, 1, -1); endtask
   task automatic test_crop();       do_scan(2'd2, 1, 2, 0, 1, 2, -1); endtask
   task automatic test_bad_crop();   do_scan(2'd2, 5, 2, 0, 1, 1, -1); endtask
   task automatic test_blur();       do_scan(2'd3, 0, 0, 0, 0, 0, -1); endtask
   task automatic test_one_pixel();  do_scan(2'd2, 3, 3, 2, 2, 0, -1); endtask
   task automatic test_abort();      do_scan(2'd0, 0, 0, 0, 0, 1, 4);  endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 20; i++)
         do_scan(2'($urandom), $urandom_range(W), $urandom_range(W), $urandom_range(H),
                 $urandom_range(H), $urandom_range(2), ($urandom_range(3) == 0) ? $urandom_range(3) : -1);
   endtask

   task automatic test_reset_mid_scan();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_sel = 2'd1;
      @(negedge clk);
      cmd_valid = 1'b0; pix_ready = 1'b1;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({pix_valid, pix_x, pix_y, pix_sel, pix_last, busy, done, err} !== 39'd0)
         $display("FAIL async_reset got v=%b x=%0d y=%0d sel=%0d last=%b busy=%b want all 0",
                  pix_valid, pix_x, pix_y, pix_sel, pix_last, busy);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1; pix_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if ({done, err, pix_valid, cmd_ready} !== 4'b0001)
            $display("FAIL post_reset got done/err/valid/ready=%b%b%b%b want 0001", done, err, pix_valid, cmd_ready);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_crop();
      test_bad_crop();
      test_blur();
      test_one_pixel();
      test_abort();
      test_back_to_back();
      test_reset_mid_scan();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
